// File: rtl/frac_best_mv_if.sv
// Stream and result bundle between frac_search and frac_best_mv.
// FRAC_BEST_MV_CHECK_EN adds the mv_err status bit.
interface frac_best_mv_if #(
    parameter int SAD_W = 12,
    parameter int ACC_W = 15,
    parameter int IDX_W = 4
);
    logic             start;
    logic             valid_in;
    logic [SAD_W-1:0] sad_in;
    logic [2:0]       mvx_in;
    logic [2:0]       mvy_in;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] best_sad;
    logic [2:0]       best_mvx;
    logic [2:0]       best_mvy;
    logic [IDX_W-1:0] best_idx;
`ifdef FRAC_BEST_MV_CHECK_EN
    logic             mv_err;

    modport master (output start, valid_in, sad_in, mvx_in, mvy_in,
                    input  busy, done, best_sad, best_mvx, best_mvy, best_idx, mv_err);
    modport slave  (input  start, valid_in, sad_in, mvx_in, mvy_in,
                    output busy, done, best_sad, best_mvx, best_mvy, best_idx, mv_err);
`else
    modport master (output start, valid_in, sad_in, mvx_in, mvy_in,
                    input  busy, done, best_sad, best_mvx, best_mvy, best_idx);
    modport slave  (input  start, valid_in, sad_in, mvx_in, mvy_in,
                    output busy, done, best_sad, best_mvx, best_mvy, best_idx);
`endif
endinterface

// File: rtl/frac_best_mv.sv
// Accumulates per-row SADs into block SADs and keeps the best of CANDS candidates.
// Optional MV consistency check under FRAC_BEST_MV_CHECK_EN.
module frac_best_mv #(
    parameter int ROWS  = 8,
    parameter int CANDS = 9,
    parameter int SAD_W = 12,
    parameter int ACC_W = 15,
    parameter int IDX_W = 4
) (
    input  logic clk,
    input  logic reset,
    frac_best_mv_if.slave bus
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] cand_q, cand_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [2:0]       cur_mvx_q, cur_mvx_d, cur_mvy_q, cur_mvy_d;
    logic [ACC_W-1:0] best_sad_q, best_sad_d;
    logic [2:0]       best_mvx_q, best_mvx_d, best_mvy_q, best_mvy_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic             restart;

    logic             first_row, last_row;
    logic [ACC_W-1:0] sum;
    logic [2:0]       mvx_eff, mvy_eff;

    // Row 0 starts from zero so the sum is valid on every beat, including ROWS==1.
    assign first_row = (row_q == '0);
    assign last_row  = (row_q == ROW_W'(ROWS-1));
    assign sum       = (first_row ? '0 : acc_q) + ACC_W'(bus.sad_in);
    assign mvx_eff   = first_row ? bus.mvx_in : cur_mvx_q;
    assign mvy_eff   = first_row ? bus.mvy_in : cur_mvy_q;

`ifdef FRAC_BEST_MV_CHECK_EN
    logic mv_err_q, mv_err_d;
    assign bus.mv_err = mv_err_q;
`endif

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cand_d     = cand_q;
        acc_d      = acc_q;
        cur_mvx_d  = cur_mvx_q;
        cur_mvy_d  = cur_mvy_q;
        best_sad_d = best_sad_q;
        best_mvx_d = best_mvx_q;
        best_mvy_d = best_mvy_q;
        best_idx_d = best_idx_q;
        restart    = 1'b0;
`ifdef FRAC_BEST_MV_CHECK_EN
        mv_err_d   = mv_err_q;
`endif
        case (state_q)
            IDLE:  restart = bus.start;
            ACCUM: begin
                if (bus.start) begin
                    restart = 1'b1;
                end else if (bus.valid_in) begin
                    acc_d     = sum;
                    cur_mvx_d = mvx_eff;
                    cur_mvy_d = mvy_eff;
`ifdef FRAC_BEST_MV_CHECK_EN
                    if (!first_row && (bus.mvx_in != cur_mvx_q || bus.mvy_in != cur_mvy_q))
                        mv_err_d = 1'b1;
`endif
                    if (last_row) begin
                        // Strict compare: on ties the earlier candidate is kept.
                        if (sum < best_sad_q) begin
                            best_sad_d = sum;
                            best_mvx_d = mvx_eff;
                            best_mvy_d = mvy_eff;
                            best_idx_d = cand_q;
                        end
                        row_d  = '0;
                        cand_d = cand_q + IDX_W'(1);
                        if (cand_q == IDX_W'(CANDS-1)) state_d = DONE;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                restart = bus.start;
            end
            default: state_d = IDLE;
        endcase
        if (restart) begin
            state_d    = ACCUM;
            row_d      = '0;
            cand_d     = '0;
            acc_d      = '0;
            best_sad_d = '1;
            best_mvx_d = '0;
            best_mvy_d = '0;
            best_idx_d = '0;
`ifdef FRAC_BEST_MV_CHECK_EN
            mv_err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            cand_q     <= '0;
            acc_q      <= '0;
            cur_mvx_q  <= '0;
            cur_mvy_q  <= '0;
            best_sad_q <= '1;
            best_mvx_q <= '0;
            best_mvy_q <= '0;
            best_idx_q <= '0;
`ifdef FRAC_BEST_MV_CHECK_EN
            mv_err_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            cand_q     <= cand_d;
            acc_q      <= acc_d;
            cur_mvx_q  <= cur_mvx_d;
            cur_mvy_q  <= cur_mvy_d;
            best_sad_q <= best_sad_d;
            best_mvx_q <= best_mvx_d;
            best_mvy_q <= best_mvy_d;
            best_idx_q <= best_idx_d;
`ifdef FRAC_BEST_MV_CHECK_EN
            mv_err_q   <= mv_err_d;
`endif
        end
    end

    assign bus.busy     = (state_q == ACCUM);
    assign bus.done     = (state_q == DONE);
    assign bus.best_sad = best_sad_q;
    assign bus.best_mvx = best_mvx_q;
    assign bus.best_mvy = best_mvy_q;
    assign bus.best_idx = best_idx_q;
endmodule
